// File: rtl/tia_lfsr_pkg.sv
// Shared constants and elaboration-time helpers for the TIA-style XNOR LFSR counter.
// All functions are constant functions evaluated while parameters are resolved.
package tia_lfsr_pkg;

    localparam int IDX_W = 8;
    localparam int MAX_W = 16;

    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                   input int width,
                                                   input logic [MAX_W-1:0] taps);
        logic [MAX_W-1:0] mask;
        logic             fb;
        mask = MAX_W'((32'd1 << width) - 32'd1);
        fb   = ~^(s & taps & mask);
        return ((s << 1) | {{(MAX_W-1){1'b0}}, fb}) & mask;
    endfunction

    function automatic logic [MAX_W-1:0] lfsr_state_at(input int idx,
                                                       input int width,
                                                       input logic [MAX_W-1:0] taps);
        logic [MAX_W-1:0] s;
        s = '0;
        for (int i = 0; i < idx; i++) begin
            s = lfsr_next(s, width, taps);
        end
        return s;
    endfunction

    // Number of distinct states visited from 0 before any state repeats (tail plus cycle).
    function automatic int seq_len(input int width, input logic [MAX_W-1:0] taps);
        logic [MAX_W-1:0] tort;
        logic [MAX_W-1:0] hare;
        int               power;
        int               lam;
        int               mu;
        power = 1;
        lam   = 1;
        tort  = '0;
        hare  = lfsr_next('0, width, taps);
        while (tort != hare) begin
            if (power == lam) begin
                tort  = hare;
                power = power * 2;
                lam   = 0;
            end
            hare = lfsr_next(hare, width, taps);
            lam  = lam + 1;
        end
        tort = '0;
        hare = '0;
        for (int i = 0; i < lam; i++) begin
            hare = lfsr_next(hare, width, taps);
        end
        mu = 0;
        while (tort != hare) begin
            tort = lfsr_next(tort, width, taps);
            hare = lfsr_next(hare, width, taps);
            mu   = mu + 1;
        end
        return mu + lam;
    endfunction

    // Entry 0 is the leftmost field of the packed concatenation.
    function automatic int decode_idx_at(input logic [8*IDX_W-1:0] packed_idx,
                                         input int num,
                                         input int i);
        return int'(packed_idx[(num-1-i)*IDX_W +: IDX_W]);
    endfunction

endpackage

// File: rtl/tia_lfsr_decode.sv
// Registered bank of state decodes: each bit compares the state being loaded against the
// precomputed LFSR state at its step index, so match lines up with out.
module tia_lfsr_decode
    import tia_lfsr_pkg::*;
#(
    parameter int                      WIDTH      = 6,
    parameter logic [WIDTH-1:0]        TAP_MASK   = 6'b110000,
    parameter int                      PERIOD     = 57,
    parameter int                      NUM_DECODE = 4,
    parameter logic [8*NUM_DECODE-1:0] DECODE_IDX = {8'd0, 8'd16, 8'd32, 8'd56}
) (
    input  logic                  clk,
    input  logic                  rl,
    input  logic                  en,
    input  logic [WIDTH-1:0]      state_d,
    output logic [NUM_DECODE-1:0] match
);

    logic [NUM_DECODE-1:0] hit;
    logic [NUM_DECODE-1:0] reset_val;

    for (genvar i = 0; i < NUM_DECODE; i++) begin : g_dec
        localparam int DIDX =
            decode_idx_at((8*IDX_W)'(DECODE_IDX), NUM_DECODE, i);
        localparam logic [WIDTH-1:0] DSTATE =
            WIDTH'(lfsr_state_at(DIDX, WIDTH, MAX_W'(TAP_MASK)));

        if (DIDX >= PERIOD) begin : g_bad_idx
            $fatal(1, "tia_lfsr_decode: decode index out of range");
        end

        assign hit[i]       = (state_d == DSTATE);
        assign reset_val[i] = (DSTATE == '0);
    end

    always_ff @(posedge clk) begin
        if (!rl) begin
            match <= reset_val;
        end else if (en) begin
            match <= hit;
        end
    end

endmodule

// File: rtl/tia_lfsr_counter.sv
// Parametrised XNOR LFSR counter with wrap/sync-reset strobes and registered decodes.
// Define TIA_LFSR_INDEX_EN to add the binary step index output idx.
module tia_lfsr_counter
    import tia_lfsr_pkg::*;
#(
    parameter int                      WIDTH      = 6,
    parameter logic [WIDTH-1:0]        TAP_MASK   = 6'b110000,
    parameter int                      PERIOD     = 57,
    parameter int                      NUM_DECODE = 4,
    parameter logic [8*NUM_DECODE-1:0] DECODE_IDX = {8'd0, 8'd16, 8'd32, 8'd56}
) (
    input  logic                  clk,
    input  logic                  rl,
    input  logic                  en,
    input  logic                  rsyn,
    output logic [WIDTH-1:0]      out,
    output logic                  wrap,
    output logic                  rsynd,
    output logic [NUM_DECODE-1:0] match
`ifdef TIA_LFSR_INDEX_EN
    ,
    output logic [IDX_W-1:0]      idx
`endif
);

    localparam logic [WIDTH-1:0] END_STATE =
        WIDTH'(lfsr_state_at(PERIOD - 1, WIDTH, MAX_W'(TAP_MASK)));

    if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
        $fatal(1, "tia_lfsr_counter: WIDTH out of range");
    end
    if (NUM_DECODE < 1 || NUM_DECODE > 8) begin : g_bad_num
        $fatal(1, "tia_lfsr_counter: NUM_DECODE out of range");
    end
    if (PERIOD < 2 || PERIOD > seq_len(WIDTH, MAX_W'(TAP_MASK))) begin : g_bad_period
        $fatal(1, "tia_lfsr_counter: PERIOD exceeds zero-start sequence length");
    end

    logic             pending;
    logic             load_zero;
    logic [WIDTH-1:0] state_nat;
    logic [WIDTH-1:0] state_d;

    // A pending or same-edge rsyn and the natural end of period all collapse into one load of 0.
    always_comb begin
        state_nat = WIDTH'(lfsr_next(MAX_W'(out), WIDTH, MAX_W'(TAP_MASK)));
        load_zero = pending || rsyn || (out == END_STATE);
        state_d   = load_zero ? '0 : state_nat;
        if (!rl) begin
            state_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rl) begin
            out     <= '0;
            pending <= 1'b0;
            wrap    <= 1'b0;
            rsynd   <= 1'b0;
        end else begin
            wrap  <= 1'b0;
            rsynd <= 1'b0;
            if (en) begin
                out     <= state_d;
                pending <= 1'b0;
                wrap    <= load_zero;
                rsynd   <= pending || rsyn;
            end else if (rsyn) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef TIA_LFSR_INDEX_EN
    always_ff @(posedge clk) begin
        if (!rl) begin
            idx <= '0;
        end else if (en) begin
            idx <= load_zero ? '0 : idx + 1'b1;
        end
    end
`endif

    tia_lfsr_decode #(
        .WIDTH      (WIDTH),
        .TAP_MASK   (TAP_MASK),
        .PERIOD     (PERIOD),
        .NUM_DECODE (NUM_DECODE),
        .DECODE_IDX (DECODE_IDX)
    ) u_decode (
        .clk     (clk),
        .rl      (rl),
        .en      (en),
        .state_d (state_d),
        .match   (match)
    );

endmodule

// File: tb/tb_tia_lfsr_counter.sv
// Self-checking bench for tia_lfsr_counter: a step-index model with a precomputed state table.
// Directed scenarios first, then randomized reset/enable/rsyn traffic.
module tb_tia_lfsr_counter;

    localparam int P  = 57;
    localparam int ND = 4;
    localparam int DEC [ND] = '{0, 16, 32, 56};

    logic        clk  = 1'b0;
    logic        rl   = 1'b0;
    logic        en   = 1'b0;
    logic        rsyn = 1'b0;
    logic [5:0]  out;
    logic        wrap;
    logic        rsynd;
    logic [3:0]  match;
`ifdef TIA_LFSR_INDEX_EN
    logic [7:0]  idx;
`endif

    int seqTable [P];
    int mK;
    bit mPend;
    bit mWrap;
    bit mRsynd;
    int assertCount = 0;
    int failCount   = 0;
    int wrapSeen;

    tia_lfsr_counter dut (
        .clk   (clk),
        .rl    (rl),
        .en    (en),
        .rsyn  (rsyn),
        .out   (out),
        .wrap  (wrap),
        .rsynd (rsynd),
        .match (match)
`ifdef TIA_LFSR_INDEX_EN
        ,
        .idx   (idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (step %0d)", tag, obs, exp, mK);
        end
    endtask

    // State table built from the step rule with integer arithmetic: new LSB = XNOR of bits 5,4.
    task automatic buildSequence();
        int s;
        int fb;
        s = 0;
        for (int k = 0; k < P; k++) begin
            seqTable[k] = s;
            fb = (((s >> 5) & 1) == ((s >> 4) & 1)) ? 1 : 0;
            s  = ((s << 1) & 63) | fb;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s);
        bit         ld;
        logic [3:0] expMatch;
        @(negedge clk);
        rl   = r;
        en   = e;
        rsyn = s;
        @(posedge clk);
        if (!r) begin
            mK = 0; mPend = 0; mWrap = 0; mRsynd = 0;
        end else if (e) begin
            ld     = mPend || s || (mK == P - 1);
            mRsynd = mPend || s;
            mWrap  = ld;
            mK     = ld ? 0 : mK + 1;
            mPend  = 0;
        end else begin
            mWrap  = 0;
            mRsynd = 0;
            if (s) mPend = 1;
        end
        #1;
        for (int i = 0; i < ND; i++) expMatch[i] = (mK == DEC[i]);
        checkOutput("out",   32'(out),   32'(seqTable[mK]));
        checkOutput("wrap",  32'(wrap),  32'(mWrap));
        checkOutput("rsynd", 32'(rsynd), 32'(mRsynd));
        checkOutput("match", 32'(match), 32'(expMatch));
`ifdef TIA_LFSR_INDEX_EN
        checkOutput("idx",   32'(idx),   32'(mK));
`endif
        if (wrap === 1'b1) wrapSeen++;
    endtask

    task automatic goToStep(input int target);
        int guard;
        guard = 0;
        while (mK != target && guard < 200) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        buildSequence();
        mK = 0; mPend = 0; mWrap = 0; mRsynd = 0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("reset_match", 32'(match), 32'd1);

        wrapSeen = 0;
        for (int i = 0; i < 120; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("wrap_count_cont", 32'(wrapSeen), 32'd2);

        applyStimulus(1'b0, 1'b0, 1'b0);
        wrapSeen = 0;
        for (int i = 0; i < 3 * 114; i++) applyStimulus(1'b1, (i % 3) == 0, 1'b0);
        checkOutput("wrap_count_sparse", 32'(wrapSeen), 32'd2);

        goToStep(20);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rsyn_deferred_out", 32'(out), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        goToStep(P - 1);
        wrapSeen = 0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rsyn_at_end_wraps", 32'(wrapSeen), 32'd1);
        checkOutput("rsyn_at_end_next", 32'(out), 32'd1);

        goToStep(40);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midreset_match", 32'(match), 32'd1);
        for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 64) != 0, ($urandom % 2) == 0, ($urandom % 16) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
